soc_pll_reset_ctrl: RTL and testbench

//  Consumer side of the SoC PLL rst/locked interface. Drives the PLL rst input, synchronises
//  and qualifies the PLL locked output, and re-locks the PLL on timeout or loss of lock.

---
 rtl/soc_pll_reset_ctrl_pkg.sv | 26 ++
 rtl/soc_pll_reset_ctrl_sync.sv | 21 ++
 rtl/soc_pll_reset_ctrl.sv | 153 +++++++++++++++
 tb/tb_soc_pll_reset_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/soc_pll_reset_ctrl_pkg.sv
// Shared types for the PLL reset controller: FSM state encoding and timer sizing helper.
package soc_pll_rst_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        HALT      = 3'd4
    } state_t;

    // Bits needed to hold 0..max(a,b,c)-1; never less than one bit.
    function automatic int clog2_max(input int a, input int b, input int c);
        int m;
        int w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < m) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/soc_pll_reset_ctrl_sync.sv
// Generic two-flop synchroniser with synchronous active-high reset to 0.
module soc_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_pll_reset_ctrl.sv
// PLL rst/locked consumer on refclk: restarts the PLL, qualifies lock, gates sys_rst.
// SOC_PLL_RST_CTRL_STATUS_EN enables the relock/timeout status counters.
module soc_pll_reset_ctrl
    import soc_pll_rst_pkg::*;
#(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 8,
    parameter int CNT_W          = 8
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             lock_lost,
    output logic             lock_fail,
    output logic [CNT_W-1:0] relock_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [2:0]       state_dbg
);

    localparam int TW = clog2_max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RW = clog2_max(MAX_RETRIES, 1, 1);

    localparam logic [TW-1:0] RST_LAST   = TW'(PLL_RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(LOCK_TIMEOUT - 1);
    // The WAIT_LOCK cycle that first sees lock already counts as stable cycle one.
    localparam logic [TW-1:0] STB_LAST   = TW'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES - 1);

    state_t        state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retries;
    logic          locked_s;
    logic          timeout_evt;
    logic          lost_evt;

    soc_sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    assign timeout_evt = (state == WAIT_LOCK) && !locked_s && (timer == TO_LAST);
    assign lost_evt    = (state == RUN) && !locked_s;
    assign state_dbg   = state;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= RESET_PLL;
            timer     <= '0;
            retries   <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            lock_lost <= 1'b0;
            lock_fail <= 1'b0;
        end else begin
            lock_lost <= 1'b0;
            case (state)
                RESET_PLL: begin
                    sys_rst <= 1'b1;
                    if (timer == RST_LAST) begin
                        state   <= WAIT_LOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer   <= timer + 1'b1;
                        pll_rst <= 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        timer <= '0;
                        if (STABLE_CYCLES == 1) begin
                            state   <= RUN;
                            sys_rst <= 1'b0;
                            retries <= '0;
                        end else begin
                            state <= STABLE;
                        end
                    end else if (timeout_evt) begin
                        timer   <= '0;
                        pll_rst <= 1'b1;
                        if (retries == RETRY_LAST) begin
                            state     <= HALT;
                            lock_fail <= 1'b1;
                        end else begin
                            state   <= RESET_PLL;
                            retries <= retries + 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STABLE: begin
                    // A dropout here is treated as a glitch: no PLL restart, no retry charged.
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                    end else if (timer == STB_LAST) begin
                        state   <= RUN;
                        timer   <= '0;
                        sys_rst <= 1'b0;
                        retries <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RUN: begin
                    if (lost_evt) begin
                        state     <= RESET_PLL;
                        timer     <= '0;
                        lock_lost <= 1'b1;
                        pll_rst   <= 1'b1;
                        sys_rst   <= 1'b1;
                    end
                end
                HALT: begin
                    pll_rst   <= 1'b1;
                    sys_rst   <= 1'b1;
                    lock_fail <= 1'b1;
                end
                default: begin
                    state   <= RESET_PLL;
                    timer   <= '0;
                    pll_rst <= 1'b1;
                    sys_rst <= 1'b1;
                end
            endcase
        end
    end

`ifdef SOC_PLL_RST_CTRL_STATUS_EN
    always_ff @(posedge refclk) begin
        if (rst) begin
            relock_cnt  <= '0;
            timeout_cnt <= '0;
        end else begin
            if (lost_evt && (relock_cnt != '1))
                relock_cnt <= relock_cnt + 1'b1;
            if (timeout_evt && (timeout_cnt != '1))
                timeout_cnt <= timeout_cnt + 1'b1;
        end
    end
`else
    assign relock_cnt  = '0;
    assign timeout_cnt = '0;
`endif

endmodule

// File: tb/tb_soc_pll_reset_ctrl.sv
// Directed and randomized checks of soc_pll_reset_ctrl against arithmetic timing predictions.
module tb_soc_pll_reset_ctrl;

  localparam int PR   = 4;
  localparam int LT   = 32;
  localparam int SC   = 8;
  localparam int MR   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int BOUND = PR + LT + 2 * SC + 10;
`ifdef SOC_PLL_RST_CTRL_STATUS_EN
  localparam bit STATUS = 1'b1;
`else
  localparam bit STATUS = 1'b0;
`endif

  logic          refclk = 1'b0;
  logic          rst;
  logic          pll_locked;
  logic          pll_rst;
  logic          sys_rst;
  logic          lock_lost;
  logic          lock_fail;
  logic [CW-1:0] relock_cnt;
  logic [CW-1:0] timeout_cnt;
  logic [2:0]    state_dbg;

  int checks = 0;
  int errors = 0;

  // clock / reset block
  initial forever #20 refclk = ~refclk;

  soc_pll_reset_ctrl #(
    .PLL_RST_CYCLES (PR),
    .LOCK_TIMEOUT   (LT),
    .STABLE_CYCLES  (SC),
    .MAX_RETRIES    (MR),
    .CNT_W          (CW)
  ) dut (
    .refclk      (refclk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst     (pll_rst),
    .sys_rst     (sys_rst),
    .lock_lost   (lock_lost),
    .lock_fail   (lock_fail),
    .relock_cnt  (relock_cnt),
    .timeout_cnt (timeout_cnt),
    .state_dbg   (state_dbg)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int exp_cnt(input int n);
    if (!STATUS) return 0;
    return (n > CMAX) ? CMAX : n;
  endfunction

  // One-cycle rst, then every output must be at its reset value.
  task automatic reset_pulse(input string tag);
    pll_locked = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check({tag, ".flags"}, {pll_rst, sys_rst, lock_lost, lock_fail}, 4'b1100);
    check({tag, ".counters"}, {relock_cnt, timeout_cnt}, 0);
  endtask

  // From a fresh PLL restart: lock rises r cycles later, optional one-cycle dropout
  // g cycles after that. Predict the sys_rst release cycle by arithmetic.
  task automatic run_lock(input string tag, input int r, input int g);
    int k;
    int mism;
    int r_last;
    int stable_in;
    int fall;
    k = 0;
    mism = 0;
    while (sys_rst === 1'b1 && k < BOUND) begin
      if (pll_rst !== (k < PR)) mism++;
      if (k > 0 && lock_lost !== 1'b0) mism++;
      pll_locked = (k >= r) && !(g > 0 && k == r + g);
      step();
      k++;
    end
    r_last    = (g > 0) ? r + g + 1 : r;
    stable_in = (r_last + 3 > PR + 1) ? r_last + 3 : PR + 1;
    fall      = stable_in + SC - 1;
    check({tag, ".sys_rst_fall"}, k, fall);
    check({tag, ".pll_rst_window"}, mism, 0);
    check({tag, ".run_outputs"}, {pll_rst, sys_rst, lock_fail, lock_lost}, 0);
  endtask

  // From RUN: drop lock, expect the lock_lost pulse three cycles later.
  task automatic lost_lock(input string tag, input int n);
    int mism;
    mism = 0;
    pll_locked = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (lock_lost !== 1'b0 || sys_rst !== 1'b0 || pll_rst !== 1'b0) mism++;
    end
    step();
    check({tag, ".pre"}, mism, 0);
    check({tag, ".pulse"}, {lock_lost, sys_rst, pll_rst}, 3'b111);
    check({tag, ".relock_cnt"}, relock_cnt, exp_cnt(n));
  endtask

  // Lock never arrives: periodic restarts, then HALT after MR timeouts.
  task automatic halt_seq(input string tag);
    int period;
    int halt_k;
    int mism;
    logic exp_rst;
    logic exp_fail;
    int exp_to;
    period = PR + LT;
    halt_k = MR * period;
    mism = 0;
    for (int k = 0; k <= halt_k + 5; k++) begin
      exp_fail = (k >= halt_k);
      exp_rst  = exp_fail || ((k % period) < PR);
      exp_to   = exp_cnt(exp_fail ? MR : k / period);
      if (pll_rst !== exp_rst || lock_fail !== exp_fail || sys_rst !== 1'b1) mism++;
      if (32'(timeout_cnt) !== 32'(exp_to)) mism++;
      if (k < halt_k + 5) step();
    end
    check({tag, ".sequence"}, mism, 0);
    check({tag, ".halt"}, {lock_fail, pll_rst, sys_rst}, 3'b111);
    check({tag, ".timeout_cnt"}, timeout_cnt, exp_cnt(MR));
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    step();
    step();

    reset_pulse("t1.reset");
    run_lock("t1", 10, 0);

    reset_pulse("t3.reset");
    run_lock("t3", 10, 5);

    lost_lock("t4", 1);
    run_lock("t4.relock", 10, 0);

    reset_pulse("t5.run_reset");
    run_lock("t5.restart", $urandom_range(0, PR + LT - 3), 0);

    reset_pulse("t2.reset");
    halt_seq("t2");

    reset_pulse("t5.halt_reset");
    run_lock("t5.lock_on_timeout_edge", PR + LT - 3, 0);

    for (int i = 0; i < 8; i++) begin
      int r;
      int g;
      g = $urandom_range(0, SC - 1);
      r = (g > 0) ? $urandom_range(PR - 2, PR + LT - 3) : $urandom_range(0, PR + LT - 3);
      reset_pulse("rnd.reset");
      run_lock("rnd", r, g);
      if ($urandom_range(0, 1) == 1) begin
        lost_lock("rnd.lost", 1);
        run_lock("rnd.relock", $urandom_range(0, PR + LT - 3), 0);
      end
    end

    reset_pulse("sat.reset");
    run_lock("sat.first", 10, 0);
    for (int n = 1; n <= CMAX + 2; n++) begin
      lost_lock("sat.lost", n);
      run_lock("sat.relock", $urandom_range(0, 12), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
